// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: LDM opcode and FSM encoding.
package fetch_stage_pkg;

  localparam logic [4:0] OP_LDM = 5'b10100;

  typedef enum logic [2:0] {
    BOOT_HI = 3'd0,
    BOOT_LO = 3'd1,
    RUN     = 3'd2,
    IMM     = 3'd3,
    FLUSH   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_flush_counter.sv
// 2-bit bubble counter: clear, load, decrement or hold, with a last-bubble flag.
module fetch_flush_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [1:0] load_val,
  input  logic       dec,
  output logic       last
);

  logic [1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 2'd0)) begin
      count <= count - 2'd1;
    end
  end

  // A zero count also counts as last so FLUSH can never get stuck.
  assign last = (count <= 2'd1);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: boots the PC from imem, fetches into IF/ID, tags LDM immediates.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     PC_W      = 32,
  parameter int unsigned     INSTR_W   = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               flush_load,
  input  logic [1:0]         flush_num,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc_next,
  output logic               ifid_valid,
  output logic               ifid_is_imm,
  output logic [2:0]         fetch_state
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] boot_hi_q, boot_hi_d;
  logic [INSTR_W-1:0] instr_d;
  logic [PC_W-1:0]    pc_next_d;
  logic               valid_d, is_imm_d;
  logic               cnt_clr, cnt_load, cnt_dec, cnt_last;
  logic [1:0]         cnt_load_val;
  logic [4:0]         opcode;

  assign opcode = imem_data[INSTR_W-1 -: 5];

  always_comb begin
    case (state_q)
      BOOT_HI: imem_addr = RESET_VEC;
      BOOT_LO: imem_addr = RESET_VEC + PC_W'(1);
      default: imem_addr = pc_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    boot_hi_d    = boot_hi_q;
    instr_d      = ifid_instr;
    pc_next_d    = ifid_pc_next;
    valid_d      = ifid_valid;
    is_imm_d     = ifid_is_imm;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    // The load edge itself emits the first bubble, so only N-1 remain counted.
    cnt_load_val = flush_num - 2'd1;
    case (state_q)
      BOOT_HI: begin
        boot_hi_d = imem_data;
        state_d   = BOOT_LO;
      end
      BOOT_LO: begin
        pc_d    = PC_W'({boot_hi_q, imem_data});
        state_d = RUN;
      end
      default: begin
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          valid_d  = 1'b0;
          is_imm_d = 1'b0;
          cnt_clr  = 1'b1;
          state_d  = RUN;
        end else if (flush_load && (flush_num != 2'd0)) begin
          cnt_load = 1'b1;
          valid_d  = 1'b0;
          is_imm_d = 1'b0;
          state_d  = (flush_num == 2'd1) ? RUN : FLUSH;
        end else if (!stall) begin
          if (state_q == FLUSH) begin
            valid_d  = 1'b0;
            is_imm_d = 1'b0;
            cnt_dec  = 1'b1;
            if (cnt_last) state_d = RUN;
          end else begin
            instr_d   = imem_data;
            pc_next_d = pc_q + PC_W'(1);
            valid_d   = 1'b1;
            is_imm_d  = (state_q == IMM);
            pc_d      = pc_q + PC_W'(1);
            state_d   = ((state_q == RUN) && (opcode == OP_LDM)) ? IMM : RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT_HI;
      pc_q         <= '0;
      boot_hi_q    <= '0;
      ifid_instr   <= '0;
      ifid_pc_next <= '0;
      ifid_valid   <= 1'b0;
      ifid_is_imm  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      boot_hi_q    <= boot_hi_d;
      ifid_instr   <= instr_d;
      ifid_pc_next <= pc_next_d;
      ifid_valid   <= valid_d;
      ifid_is_imm  <= is_imm_d;
    end
  end

  fetch_flush_counter u_flush_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  assign fetch_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational imem model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        flush_load = 1'b0;
  logic [1:0]  flush_num = '0;
  logic [15:0] ifid_instr;
  logic [31:0] ifid_pc_next;
  logic        ifid_valid;
  logic        ifid_is_imm;
  logic [2:0]  fetch_state;

  logic [15:0] mem [0:511];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Low 512 words come from the table; higher addresses return ~addr.
  assign imem_data = (imem_addr < 32'd512) ? mem[imem_addr[8:0]] : ~imem_addr[15:0];

  fetch_stage #(.PC_W(32), .INSTR_W(16), .RESET_VEC(32'd0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_load     (flush_load),
    .flush_num      (flush_num),
    .ifid_instr     (ifid_instr),
    .ifid_pc_next   (ifid_pc_next),
    .ifid_valid     (ifid_valid),
    .ifid_is_imm    (ifid_is_imm),
    .fetch_state    (fetch_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (fetch_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fetch_state); end
    checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    checks++; if ({ifid_instr, ifid_pc_next, ifid_valid, ifid_is_imm} !== 50'd0) begin failures++; $display("FAIL reset_ifid got=%h/%h/%b/%b exp=0", ifid_instr, ifid_pc_next, ifid_valid, ifid_is_imm); end
  endtask

  task automatic test_boot();
    rst = 1'b0;
    step();
    checks++; if (fetch_state !== 3'd1 || imem_addr !== 32'd1 || ifid_valid !== 1'b0) begin failures++; $display("FAIL boot_lo got=%0d/%h/%b exp=1/00000001/0", fetch_state, imem_addr, ifid_valid); end
    step();
    checks++; if (fetch_state !== 3'd2 || imem_addr !== 32'h20 || ifid_valid !== 1'b0) begin failures++; $display("FAIL boot_run got=%0d/%h/%b exp=2/00000020/0", fetch_state, imem_addr, ifid_valid); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 16'hA000 || ifid_pc_next !== 32'h21 || ifid_is_imm !== 1'b0) begin failures++; $display("FAIL boot_first got=%b/%h/%h/%b exp=1/a000/00000021/0", ifid_valid, ifid_instr, ifid_pc_next, ifid_is_imm); end
    checks++; if (fetch_state !== 3'd3) begin failures++; $display("FAIL ldm_to_imm got=%0d exp=3", fetch_state); end
  endtask

  task automatic test_ldm();
    stall = 1'b1;
    step();
    checks++; if (fetch_state !== 3'd3 || ifid_instr !== 16'hA000 || imem_addr !== 32'h21 || ifid_is_imm !== 1'b0) begin failures++; $display("FAIL stall_imm got=%0d/%h/%h/%b exp=3/a000/00000021/0", fetch_state, ifid_instr, imem_addr, ifid_is_imm); end
    stall = 1'b0;
    step();
    checks++; if (ifid_instr !== 16'hA123 || ifid_is_imm !== 1'b1 || ifid_pc_next !== 32'h22 || fetch_state !== 3'd2) begin failures++; $display("FAIL ldm_imm got=%h/%b/%h/%0d exp=a123/1/00000022/2", ifid_instr, ifid_is_imm, ifid_pc_next, fetch_state); end
    step();
    checks++; if (ifid_instr !== 16'h0822 || ifid_is_imm !== 1'b0 || ifid_valid !== 1'b1 || fetch_state !== 3'd2) begin failures++; $display("FAIL ldm_after got=%h/%b/%b/%0d exp=0822/0/1/2", ifid_instr, ifid_is_imm, ifid_valid, fetch_state); end
  endtask

  task automatic test_redirect_imm();
    redirect_to(32'h20);
    checks++; if (ifid_valid !== 1'b0 || imem_addr !== 32'h20) begin failures++; $display("FAIL redir_bubble got=%b/%h exp=0/00000020", ifid_valid, imem_addr); end
    step();
    checks++; if (fetch_state !== 3'd3 || ifid_instr !== 16'hA000) begin failures++; $display("FAIL redir_ldm got=%0d/%h exp=3/a000", fetch_state, ifid_instr); end
    redirect_to(32'h100);
    checks++; if (ifid_valid !== 1'b0 || ifid_is_imm !== 1'b0 || fetch_state !== 3'd2 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_imm_cancel got=%b/%b/%0d/%h exp=0/0/2/00000100", ifid_valid, ifid_is_imm, fetch_state, imem_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 16'h0900 || ifid_is_imm !== 1'b0 || ifid_pc_next !== 32'h101) begin failures++; $display("FAIL redir_target got=%b/%h/%b/%h exp=1/0900/0/00000101", ifid_valid, ifid_instr, ifid_is_imm, ifid_pc_next); end
  endtask

  task automatic test_flush();
    int nb;
    redirect_to(32'h40);
    flush_load = 1'b1;
    flush_num  = 2'd3;
    step();
    flush_load = 1'b0;
    checks++; if (fetch_state !== 3'd4) begin failures++; $display("FAIL flush_enter got=%0d exp=4", fetch_state); end
    nb = 0;
    while (ifid_valid === 1'b0 && nb < 8) begin
      nb++;
      checks++; if (imem_addr !== 32'h40) begin failures++; $display("FAIL flush_pc_hold got=%h exp=00000040", imem_addr); end
      step();
    end
    checks++; if (nb !== 3) begin failures++; $display("FAIL flush3_count got=%0d exp=3", nb); end
    checks++; if (ifid_instr !== 16'h0840 || ifid_pc_next !== 32'h41) begin failures++; $display("FAIL flush3_resume got=%h/%h exp=0840/00000041", ifid_instr, ifid_pc_next); end

    redirect_to(32'h40);
    flush_load = 1'b1;
    flush_num  = 2'd3;
    step();
    flush_load = 1'b0;
    step();
    stall = 1'b1;
    step();
    stall = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || fetch_state !== 3'd4) begin failures++; $display("FAIL flush_stall_hold got=%b/%0d exp=0/4", ifid_valid, fetch_state); end
    step();
    checks++; if (ifid_valid !== 1'b0 || fetch_state !== 3'd2) begin failures++; $display("FAIL flush_stall_b4 got=%b/%0d exp=0/2", ifid_valid, fetch_state); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 16'h0840) begin failures++; $display("FAIL flush_stall_resume got=%b/%h exp=1/0840", ifid_valid, ifid_instr); end

    redirect_to(32'h40);
    flush_load = 1'b1;
    flush_num  = 2'd1;
    step();
    flush_load = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || fetch_state !== 3'd2) begin failures++; $display("FAIL flush1_bubble got=%b/%0d exp=0/2", ifid_valid, fetch_state); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 16'h0840) begin failures++; $display("FAIL flush1_resume got=%b/%h exp=1/0840", ifid_valid, ifid_instr); end

    redirect_to(32'h40);
    flush_load = 1'b1;
    flush_num  = 2'd0;
    step();
    flush_load = 1'b0;
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 16'h0840 || fetch_state !== 3'd2) begin failures++; $display("FAIL flush0_ignored got=%b/%h/%0d exp=1/0840/2", ifid_valid, ifid_instr, fetch_state); end
  endtask

  task automatic test_wrap_priority();
    redirect_to(32'hFFFF_FFFF);
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc_next !== 32'h0 || imem_addr !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%b/%h/%h exp=1/00000000/00000000", ifid_valid, ifid_pc_next, imem_addr); end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h30;
    flush_load     = 1'b1;
    flush_num      = 2'd3;
    stall          = 1'b1;
    step();
    redirect_valid = 1'b0;
    flush_load     = 1'b0;
    stall          = 1'b0;
    checks++; if (ifid_valid !== 1'b0 || fetch_state !== 3'd2 || imem_addr !== 32'h30) begin failures++; $display("FAIL prio_redirect got=%b/%0d/%h exp=0/2/00000030", ifid_valid, fetch_state, imem_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 16'h0830 || ifid_pc_next !== 32'h31) begin failures++; $display("FAIL prio_fetch got=%b/%h/%h exp=1/0830/00000031", ifid_valid, ifid_instr, ifid_pc_next); end
  endtask

  task automatic test_reset_mid_flush();
    flush_load = 1'b1;
    flush_num  = 2'd3;
    step();
    flush_load = 1'b0;
    checks++; if (fetch_state !== 3'd4) begin failures++; $display("FAIL rstflush_enter got=%0d exp=4", fetch_state); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (fetch_state !== 3'd0 || imem_addr !== 32'd0 || {ifid_instr, ifid_pc_next, ifid_valid, ifid_is_imm} !== 50'd0) begin failures++; $display("FAIL rstflush_values got=%0d/%h/%h/%h/%b exp=0/0/0/0/0", fetch_state, imem_addr, ifid_instr, ifid_pc_next, ifid_valid); end
    step();
    step();
    checks++; if (fetch_state !== 3'd2 || imem_addr !== 32'h20) begin failures++; $display("FAIL rstflush_boot got=%0d/%h exp=2/00000020", fetch_state, imem_addr); end
    step();
    checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 16'hA000 || ifid_pc_next !== 32'h21) begin failures++; $display("FAIL rstflush_first got=%b/%h/%h exp=1/a000/00000021", ifid_valid, ifid_instr, ifid_pc_next); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = {5'b00001, 11'(i)};
    mem[0]     = 16'h0000;
    mem[1]     = 16'h0020;
    mem[9'h20] = 16'hA000;
    mem[9'h21] = 16'hA123;
    test_reset();
    test_boot();
    test_ldm();
    test_redirect_imm();
    test_flush();
    test_wrap_priority();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined processor, directly upstream of the decode/control unit. It owns the PC, boots from a reset vector held in instruction memory, and fills the IF/ID pipeline register. It tags the second word of two-word LDM instructions so decode never interprets an immediate as an opcode. It also applies stalls, taken-branch redirects, and the bubble counts requested for RET/RTI.

## Interface
Parameters:
- PC_W, 32, PC and instruction-memory address width
- INSTR_W, 16, instruction word width; opcode is instr[INSTR_W-1 -: 5]
- RESET_VEC, 0, word address of the boot vector: high half at RESET_VEC, low half at RESET_VEC+1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  PC_W  instruction-memory word address (combinational from state/PC)
- imem_data  in  INSTR_W  word at imem_addr, combinational read, same cycle
- stall  in  1  hold PC, state, flush counter and IF/ID contents
- redirect_valid  in  1  taken branch/call/ret from a later stage
- redirect_pc  in  PC_W  redirect target
- flush_load  in  1  start a bubble sequence
- flush_num  in  2  bubbles to insert (RET=2, RTI=3)
- ifid_instr  out  INSTR_W  fetched word
- ifid_pc_next  out  PC_W  fetch address + 1
- ifid_valid  out  1  0 = bubble; decode treats as NOP
- ifid_is_imm  out  1  word is an LDM immediate; opcode field is not decoded
- fetch_state  out  3  current FSM state, for the hazard unit and debug

## Operation
- States: BOOT_HI, BOOT_LO, RUN, IMM, FLUSH.
- imem_addr:
  - BOOT_HI: RESET_VEC
  - BOOT_LO: RESET_VEC+1
  - otherwise: PC
- BOOT_HI: latch imem_data as boot_hi → BOOT_LO.
- BOOT_LO: PC ← {boot_hi, imem_data}, truncated/zero-extended to PC_W → RUN. ifid_valid=0 throughout boot.
- During boot, stall, redirect_valid and flush_load are ignored.
- RUN/IMM, normal fetch:
  - ifid_instr ← imem_data; ifid_pc_next ← PC+1; ifid_valid ← 1; PC ← PC+1.
  - ifid_is_imm ← 1 when the fetch happens in IMM.
- Opcode test (RUN only): a fetched word with opcode == OP_LDM → IMM; otherwise stay RUN.
- IMM → RUN after one fetch, regardless of the immediate's bit pattern; LDMs never chain.
- Priority in RUN/IMM/FLUSH: redirect_valid > flush_load > stall > normal fetch.
- Redirect:
  - PC ← redirect_pc; IF/ID ← bubble (valid=0, is_imm=0); state → RUN; flush counter ← 0.
  - Any pending IMM or FLUSH is cancelled.
- flush_load with flush_num>0: counter ← flush_num; IF/ID ← bubble; PC held; → FLUSH.
- flush_load with flush_num==0: ignored, normal fetch.
- FLUSH:
  - Each unstalled cycle emits a bubble, holds PC and decrements the counter.
  - When the counter equals 1, the next state is RUN.
  - flush_load inside FLUSH reloads the counter.
- stall: every register holds its value, including the counter and IMM state. Bubbles are not inserted by this block; the downstream register handles that.
- PC arithmetic is modulo 2^PC_W; PC+1 from all-ones wraps to 0.

## Timing
- Reset values:
  - state BOOT_HI; PC 0; boot_hi 0; counter 0
  - ifid_instr 0; ifid_pc_next 0; ifid_valid 0; ifid_is_imm 0
  - imem_addr = RESET_VEC
- Boot latency: in the 2nd cycle after rst deasserts, state is RUN with the vector loaded; the first valid IF/ID word appears one cycle later.
- Fetch latency: the word at PC is visible on the IF/ID outputs one edge after it is presented.
- Redirect: the word at redirect_pc is in IF/ID two edges after redirect_valid is sampled; exactly one bubble in between.
- flush_num=N: exactly N consecutive bubbles (absent stall), then the fetch resumes at the held PC.
- rst mid-operation (any state): the next edge forces the reset values and aborts IMM/FLUSH.

## Structure
- OP_LDM and the state encodings (BOOT_HI=0, BOOT_LO=1, RUN=2, IMM=3, FLUSH=4) go in the shared defines.v, alongside the existing opcode defines.
- Natural sub-module: fetch_flush_counter (2-bit load/decrement/hold counter with a last-cycle flag).
- PC, FSM and IF/ID register stay in fetch_stage.

## Test plan
- Boot: mem[0]=0x0000, mem[1]=0x0020, rst 1 cycle. Expect imem_addr 0, then 1, then 0x20; first ifid_valid=1 with ifid_pc_next=0x21 on the 3rd post-reset edge.
- LDM: LDM at 0x20, immediate 0x????=LDM-encoded at 0x21. Expect 0x21 tagged ifid_is_imm=1, 0x22 tagged 0, state RUN (no chaining).
- Redirect during IMM: redirect_pc=0x100 on the cycle after LDM fetch. Expect one bubble, is_imm never set, next valid word from 0x100.
- RTI flush: flush_load, flush_num=3 at PC=0x40. Expect exactly 3 bubbles, PC held at 0x40, then a fetch of 0x40. A stall in bubble 2 extends to 4 bubble cycles and holds the counter.
- Wrap and priority: PC=0xFFFFFFFF gives ifid_pc_next=0. Simultaneous redirect_valid, flush_load and stall gives redirect only, counter 0, state RUN.
- Reset mid-FLUSH: rst asserted with counter=2. Expect all reset values next edge, then the full boot sequence.
